// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass, hardwired zero register and a
// per-register pending-write scoreboard for operand stall detection.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_stall,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dest,
    output logic                     iss_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_dest,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     pending_any,
    output logic                     err_underflow
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc, dec;
    logic wb_live;

    assign wb_live   = wb_en && (wb_dest != '0);
    // Conservative: a same-cycle writeback does not free a saturated counter.
    assign iss_ready = !((iss_dest != '0) && (cnt[iss_dest] == CNT_MAX));

    always_comb begin
        inc = '0;
        dec = '0;
        pending_any = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r] = iss_valid && iss_ready && (iss_dest == ADDR_W'(r));
            dec[r] = wb_en && (wb_dest == ADDR_W'(r)) && (cnt[r] != '0);
            pending_any = pending_any | (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[wb_dest] <= wb_data;
            end
            if (wb_live && (cnt[wb_dest] == '0) && !flush) begin
                err_underflow <= 1'b1;
            end
            for (int r = 1; r < NUM_REGS; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit  = wb_en && (wb_dest == addr);
        assign rd_data[i*DATA_W +: DATA_W] = (addr == '0) ? '0 : (hit ? wb_data : regs[addr]);
        // The last outstanding writer landing this cycle is covered by the bypass.
        assign rd_stall[i] = (addr != '0) && (cnt[addr] != '0)
                             && !((cnt[addr] == CNT_W'(1)) && hit);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a behavioural array model.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 2;
    localparam int NREG   = 32;
    localparam int CMAX   = 3;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_stall;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_dest;
    logic                     iss_ready;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_dest;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     pending_any;
    logic                     err_underflow;

    regfile_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_stall(rd_stall), .iss_valid(iss_valid), .iss_dest(iss_dest),
        .iss_ready(iss_ready), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .flush(flush), .pending_any(pending_any), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    logic [DATA_W-1:0] mregs [NREG];
    int                mcnt  [NREG];
    bit                merr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mregs[r] = '0;
            mcnt[r]  = 0;
        end
        merr = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (wb_en && int'(wb_dest) == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic bit m_stall(input int a);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        return !(mcnt[a] == 1 && wb_en && int'(wb_dest) == a);
    endfunction

    function automatic bit m_ready();
        return !(iss_dest != 0 && mcnt[iss_dest] == CMAX);
    endfunction

    task automatic check_outputs();
        bit any;
        any = 1'b0;
        for (int r = 0; r < NREG; r++) any |= (mcnt[r] != 0);
        for (int i = 0; i < NUM_RD; i++) begin
            int a;
            a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
            check($sformatf("rd_data%0d r%0d", i, a), rd_data[i*DATA_W +: DATA_W], m_read(a));
            check($sformatf("rd_stall%0d r%0d", i, a), rd_stall[i], m_stall(a));
        end
        check("iss_ready", iss_ready, m_ready());
        check("pending_any", pending_any, any);
        check("err_underflow", err_underflow, merr);
    endtask

    // Called in the clock-edge timestep, inputs still stable.
    task automatic model_clock();
        bit accept, dec, under;
        accept = iss_valid && m_ready() && iss_dest != 0;
        dec    = wb_en && wb_dest != 0 && mcnt[wb_dest] > 0;
        under  = wb_en && wb_dest != 0 && mcnt[wb_dest] == 0 && !flush;
        if (flush) begin
            for (int r = 0; r < NREG; r++) mcnt[r] = 0;
        end else begin
            if (accept) mcnt[iss_dest] = mcnt[iss_dest] + 1;
            if (dec)    mcnt[wb_dest]  = mcnt[wb_dest] - 1;
        end
        if (under) merr = 1'b1;
        if (wb_en && wb_dest != 0) mregs[wb_dest] = wb_data;
    endtask

    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_in(input bit iv, input int id, input bit we, input int wd,
                          input logic [DATA_W-1:0] wdat, input bit fl, input int a0, input int a1);
        iss_valid = iv;
        iss_dest  = ADDR_W'(id);
        wb_en     = we;
        wb_dest   = ADDR_W'(wd);
        wb_data   = wdat;
        flush     = fl;
        rd_addr   = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    initial begin
        resetn = 1'b0;
        set_in(0, 0, 0, 0, '0, 0, 0, 0);
        model_reset();
        #1 check_outputs();
        check("reset_ready", iss_ready, 1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Async reset clears a written register without a clock edge.
        set_in(0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
        step();
        set_in(0, 0, 0, 0, '0, 0, 5, 0);
        #1 check("r5_written", rd_data[31:0], 32'hDEADBEEF);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_r5", rd_data[31:0], 0);
        check("async_rst_pend", pending_any, 0);
        check("async_rst_err", err_underflow, 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // Stall until writeback, bypass in the writeback cycle.
        set_in(1, 3, 0, 0, '0, 0, 3, 0);
        step();
        set_in(0, 0, 0, 0, '0, 0, 3, 0);
        #1 check("t2_stall_wait", rd_stall[0], 1);
        step();
        set_in(0, 0, 1, 3, 32'h12345678, 0, 3, 0);
        #1 check("t2_stall_wb", rd_stall[0], 0);
        check("t2_bypass", rd_data[31:0], 32'h12345678);
        step();
        set_in(0, 0, 0, 0, '0, 0, 3, 0);
        #1 check("t2_after", rd_stall[0], 0);
        step();

        // Saturation of r7.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 7, 0, 0, '0, 0, 7, 0);
            step();
        end
        set_in(1, 7, 0, 0, '0, 0, 7, 0);
        #1 check("t3_full", iss_ready, 0);
        step();
        set_in(0, 7, 1, 7, 32'h77, 0, 0, 0);
        step();
        set_in(0, 7, 0, 0, '0, 0, 7, 0);
        #1 check("t3_ready", iss_ready, 1);
        check("t3_stall", rd_stall[0], 1);
        step();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 1, 7, 32'h70 + k, 0, 7, 7);
            step();
        end

        // Issue and writeback to r4 in the same cycle keep cnt=1.
        set_in(1, 4, 0, 0, '0, 0, 4, 0);
        step();
        set_in(1, 4, 1, 4, 32'h44, 0, 4, 0);
        step();
        set_in(0, 0, 0, 0, '0, 0, 4, 0);
        #1 check("t4_stall", rd_stall[0], 1);
        step();
        set_in(0, 0, 1, 4, 32'h45, 0, 4, 0);
        step();

        // Underflow and zero register.
        set_in(0, 0, 0, 0, '0, 0, 9, 0);
        #1 check("t5_no_err", err_underflow, 0);
        set_in(0, 0, 1, 9, 32'h55, 0, 9, 0);
        step();
        set_in(0, 0, 1, 0, 32'hFFFFFFFF, 0, 9, 0);
        #1 check("t5_err", err_underflow, 1);
        check("t5_r9", rd_data[31:0], 32'h55);
        check("t5_r0_wb", rd_data[63:32], 0);
        step();
        set_in(0, 0, 0, 0, '0, 0, 0, 9);
        #1 check("t5_r0", rd_data[31:0], 0);
        step();

        // Flush with a concurrent writeback.
        set_in(1, 2, 0, 0, '0, 0, 2, 6);
        step();
        set_in(1, 6, 0, 0, '0, 0, 2, 6);
        step();
        set_in(0, 0, 1, 2, 32'hAA, 1, 2, 6);
        step();
        set_in(0, 0, 0, 0, '0, 0, 2, 6);
        #1 check("t6_pend", pending_any, 0);
        check("t6_r2", rd_data[31:0], 32'hAA);
        check("t6_err", err_underflow, 1);
        step();

        // Randomized traffic over a small register window to force hazards.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 resetn = 1'b0;
                #1 model_reset();
                check_outputs();
                @(negedge clk);
                resetn = 1'b1;
            end
            set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom, ($urandom_range(0, 39) == 0),
                   $urandom_range(0, 7), $urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
